// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, stall/flush,
// and a pending-write scoreboard with countdown for the multi-cycle MD unit.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   RsD/RtD/UseRsD/UseRtD  D-stage sources and their use bits
//   WriteRegD/RegWriteD    D-stage destination
//   BranchD, MdOpD         D is a branch / MD instruction
//   RsE/RtE/WriteRegE      E-stage fields; RegWriteE, MemtoRegE, MdOpE
//   WriteRegM/RegWriteM/MemtoRegM, WriteRegW/RegWriteW  later stages
//   MemReadyM              low freezes the whole pipeline
//   StallF/D/E/M, FlushE   pipeline register control
//   ForwardAE/BE           0 regfile, 1 W, 2 M ALU, 3 MD result
//   ForwardAD/BD           M ALU result to branch comparator
//   MdWbValid/MdWbReg      MD writeback strobe and destination
//   MdBusy                 MD countdown nonzero
//   StallCycles            saturating count of cycles with StallD high
module hazard_scoreboard #(
   parameter int REG_W  = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic             UseRsD,
   input  logic             UseRtD,
   input  logic [REG_W-1:0] WriteRegD,
   input  logic             RegWriteD,
   input  logic             BranchD,
   input  logic             MdOpD,
   input  logic [REG_W-1:0] RsE,
   input  logic [REG_W-1:0] RtE,
   input  logic [REG_W-1:0] WriteRegE,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic             MdOpE,
   input  logic [REG_W-1:0] WriteRegM,
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic [REG_W-1:0] WriteRegW,
   input  logic             RegWriteW,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             MdWbValid,
   output logic [REG_W-1:0] MdWbReg,
   output logic             MdBusy,
   output logic [CNT_W-1:0] StallCycles
);

   localparam int NREG = 1 << REG_W;
   localparam logic [3:0] LAT = 4'(MD_LAT);

   logic [NREG-1:0]  pend;
   logic [NREG-1:0]  pend_nxt;
   logic [3:0]       count;
   logic [REG_W-1:0] dst;
   logic             freeze;
   logic             issue;
   logic             raw_hz;
   logic             waw_hz;
   logic             str_hz;
   logic             hz;
   logic             alu_m;

   function automatic logic match(
      input logic [REG_W-1:0] x,
      input logic [REG_W-1:0] r
   );
      return (r != '0) && (x == r);
   endfunction

   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] src,
      input logic [REG_W-1:0] wm,
      input logic [REG_W-1:0] ww,
      input logic [REG_W-1:0] wmd,
      input logic             vm,
      input logic             vw,
      input logic             vmd
   );
      if (vm && match(wm, src))
         return 2'd2;
      if (vw && match(ww, src))
         return 2'd1;
      if (vmd && match(wmd, src))
         return 2'd3;
      return 2'd0;
   endfunction

   assign freeze    = ~MemReadyM;
   assign issue     = MdOpE & ~freeze;
   assign MdWbValid = (count == 4'd1);
   assign MdWbReg   = dst;
   assign MdBusy    = (count != 4'd0);
   assign alu_m     = RegWriteM & ~MemtoRegM;

   // Per-source RAW checks; a source that is not used never stalls.
   always_comb begin
      raw_hz = 1'b0;
      for (int i = 0; i < 2; i++) begin
         logic [REG_W-1:0] s;
         logic             u;
         logic             me;
         logic             mm;
         logic             sb;
         s  = (i == 0) ? RsD : RtD;
         u  = (i == 0) ? UseRsD : UseRtD;
         me = match(WriteRegE, s);
         mm = match(WriteRegM, s);
         // Regfile is write-before-read, so the writeback cycle is clear.
         sb = pend[s] & ~(MdWbValid & (MdWbReg == s));
         if (u) begin
            raw_hz = raw_hz
                   | (RegWriteE & MemtoRegE & me)
                   | (BranchD & RegWriteE & me)
                   | (BranchD & RegWriteM & MemtoRegM & mm)
                   | sb
                   | (MdOpE & me);
         end
      end
   end

   assign waw_hz = RegWriteD & (WriteRegD != '0)
                 & (pend[WriteRegD]
                   | (MdOpE & (WriteRegE == WriteRegD)));
   assign str_hz = MdOpD & (MdOpE | (count > 4'd1));
   assign hz     = raw_hz | waw_hz | str_hz;

   assign StallF = hz | freeze;
   assign StallD = hz | freeze;
   assign StallE = freeze;
   assign StallM = freeze;
   assign FlushE = hz & ~freeze;

   assign ForwardAE = fwd_sel(RsE, WriteRegM, WriteRegW, dst,
                              alu_m, RegWriteW, MdWbValid);
   assign ForwardBE = fwd_sel(RtE, WriteRegM, WriteRegW, dst,
                              alu_m, RegWriteW, MdWbValid);
   assign ForwardAD = alu_m & match(WriteRegM, RsD);
   assign ForwardBD = alu_m & match(WriteRegM, RtD);

   // Clear precedes set so a coinciding issue to the same reg stays pending.
   always_comb begin
      pend_nxt = pend;
      if (MdWbValid)
         pend_nxt[dst] = 1'b0;
      if (issue && (WriteRegE != '0))
         pend_nxt[WriteRegE] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend  <= '0;
         count <= 4'd0;
         dst   <= '0;
      end else begin
         pend <= pend_nxt;
         if (issue) begin
            count <= LAT;
            dst   <= WriteRegE;
         end else if (count != 4'd0) begin
            count <= count - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         StallCycles <= '0;
      else if (StallD && (StallCycles != '1))
         StallCycles <= StallCycles + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard: a cycle-level reference model
// predicts outputs, a queue carries them to an independent checker.
module tb_hazard_scoreboard;

   localparam int LAT = 4;
   localparam int CW  = 4;
   localparam int NCYC = 4000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] RsD, RtD, WriteRegD, RsE, RtE, WriteRegE;
   logic [4:0] WriteRegM, WriteRegW;
   logic       UseRsD, UseRtD, RegWriteD, BranchD, MdOpD;
   logic       RegWriteE, MemtoRegE, MdOpE;
   logic       RegWriteM, MemtoRegM, RegWriteW, MemReadyM;
   logic       StallF, StallD, StallE, StallM, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, MdWbValid, MdBusy;
   logic [4:0] MdWbReg;
   logic [CW-1:0] StallCycles;

   hazard_scoreboard #(.REG_W(5), .MD_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
      .WriteRegD(WriteRegD), .RegWriteD(RegWriteD),
      .BranchD(BranchD), .MdOpD(MdOpD),
      .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MdOpE(MdOpE),
      .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
      .MemtoRegM(MemtoRegM),
      .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
      .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .StallM(StallM), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .MdWbValid(MdWbValid), .MdWbReg(MdWbReg),
      .MdBusy(MdBusy), .StallCycles(StallCycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic sf, sd, se, sm, fe;
      logic [1:0] fae, fbe;
      logic fad, fbd, mdv;
      logic [4:0] mdr;
      logic busy;
      logic [CW-1:0] sc;
   } out_t;

   out_t exp_q[$];
   int   cyc_q[$];
   int   compared = 0;
   int   mismatched = 0;

   // Reference state: absolute cycle numbers of the in-flight MD op,
   // the set of registers with pending MD writes, and a plain stall tally.
   int       cyc;
   int       iss_cyc;
   int       wb_cyc;
   logic [4:0] wb_dst;
   bit [31:0] pend_m;
   int       stalls;
   bit       prev_rst;
   bit       prev_sd;

   function automatic bit m(input logic [4:0] x, input logic [4:0] r);
      return (r != 0) && (x == r);
   endfunction

   function automatic logic [1:0] fwd(input logic [4:0] s);
      if (RegWriteM && !MemtoRegM && m(WriteRegM, s)) return 2'd2;
      if (RegWriteW && m(WriteRegW, s)) return 2'd1;
      if ((cyc == wb_cyc) && m(wb_dst, s)) return 2'd3;
      return 2'd0;
   endfunction

   function automatic bit src_hz(input logic [4:0] s, input logic u);
      bit h;
      h = 0;
      if (!u) return 0;
      if (RegWriteE && MemtoRegE && m(WriteRegE, s)) h = 1;
      if (BranchD && RegWriteE && m(WriteRegE, s)) h = 1;
      if (BranchD && RegWriteM && MemtoRegM && m(WriteRegM, s)) h = 1;
      if (pend_m[s] && !((cyc == wb_cyc) && (wb_dst == s))) h = 1;
      if (MdOpE && m(WriteRegE, s)) h = 1;
      return h;
   endfunction

   function automatic out_t predict();
      out_t o;
      bit fr, h;
      fr = !MemReadyM;
      h  = src_hz(RsD, UseRsD) || src_hz(RtD, UseRtD);
      if (RegWriteD && WriteRegD != 0 &&
          (pend_m[WriteRegD] || (MdOpE && WriteRegE == WriteRegD)))
         h = 1;
      if (MdOpD && (MdOpE || (cyc > iss_cyc && cyc < wb_cyc)))
         h = 1;
      o.sf   = h || fr;
      o.sd   = h || fr;
      o.se   = fr;
      o.sm   = fr;
      o.fe   = h && !fr;
      o.fae  = fwd(RsE);
      o.fbe  = fwd(RtE);
      o.fad  = RegWriteM && !MemtoRegM && m(WriteRegM, RsD);
      o.fbd  = RegWriteM && !MemtoRegM && m(WriteRegM, RtD);
      o.mdv  = (cyc == wb_cyc);
      o.mdr  = wb_dst;
      o.busy = (cyc > iss_cyc) && (cyc <= wb_cyc);
      o.sc   = (stalls >= (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(stalls);
      return o;
   endfunction

   function automatic logic [4:0] rreg();
      if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 3));
   endfunction

   task automatic model_reset();
      iss_cyc = -100;
      wb_cyc  = -100;
      wb_dst  = 0;
      pend_m  = 0;
      stalls  = 0;
   endtask

   task automatic zero_inputs();
      {RsD, RtD, WriteRegD, RsE, RtE, WriteRegE} = '0;
      {WriteRegM, WriteRegW} = '0;
      {UseRsD, UseRtD, RegWriteD, BranchD, MdOpD} = '0;
      {RegWriteE, MemtoRegE, MdOpE} = '0;
      {RegWriteM, MemtoRegM, RegWriteW} = '0;
      MemReadyM = 1'b1;
   endtask

   // Advance the model across the clock edge using last cycle's inputs.
   task automatic model_edge();
      if (prev_sd) stalls++;
      if (cyc == wb_cyc) pend_m[wb_dst] = 1'b0;
      if (MdOpE && MemReadyM) begin
         if (WriteRegE != 0) pend_m[WriteRegE] = 1'b1;
         iss_cyc = cyc;
         wb_cyc  = cyc + LAT;
         wb_dst  = WriteRegE;
      end
      cyc++;
   endtask

   task automatic randomize_inputs();
      bit long_busy;
      long_busy = (cyc > iss_cyc) && (cyc < wb_cyc);
      RsD = rreg(); RtD = rreg(); WriteRegD = rreg();
      UseRsD = 1'($urandom_range(0, 3) != 0);
      UseRtD = 1'($urandom_range(0, 1));
      RegWriteD = 1'($urandom_range(0, 1));
      BranchD = 1'($urandom_range(0, 4) == 0);
      MdOpD = 1'($urandom_range(0, 4) == 0);
      RsE = rreg(); RtE = rreg(); WriteRegE = rreg();
      RegWriteE = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 2) == 0);
      MdOpE = long_busy ? 1'($urandom_range(0, 39) == 0)
                        : 1'($urandom_range(0, 5) == 0);
      WriteRegM = rreg();
      RegWriteM = 1'($urandom_range(0, 1));
      MemtoRegM = 1'($urandom_range(0, 2) == 0);
      WriteRegW = rreg();
      RegWriteW = 1'($urandom_range(0, 1));
      MemReadyM = 1'($urandom_range(0, 5) != 0);
   endtask

   initial begin
      int rst_left;
      rst_n = 1'b0;
      zero_inputs();
      cyc = 0;
      model_reset();
      prev_rst = 1;
      prev_sd  = 0;
      rst_left = 2;
      for (int n = 0; n < NCYC; n++) begin
         bit do_rst;
         @(posedge clk);
         #1;
         if (!prev_rst) model_edge();
         if (rst_left == 0 && $urandom_range(0, 149) == 0)
            rst_left = $urandom_range(1, 2);
         do_rst = (rst_left != 0);
         if (do_rst) begin
            rst_left--;
            rst_n = 1'b0;
            zero_inputs();
            model_reset();
         end else begin
            rst_n = 1'b1;
            randomize_inputs();
         end
         #0;
         begin
            out_t e;
            e = predict();
            exp_q.push_back(e);
            cyc_q.push_back(n);
            prev_sd = e.sd;
         end
         prev_rst = do_rst;
      end
      @(negedge clk);
      #1;
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expected entries left, want 0",
                  exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         out_t e, a;
         int   n;
         e = exp_q.pop_front();
         n = cyc_q.pop_front();
         a = {StallF, StallD, StallE, StallM, FlushE,
              ForwardAE, ForwardBE, ForwardAD, ForwardBD,
              MdWbValid, MdWbReg, MdBusy, StallCycles};
         compared++;
         if (a !== e) begin
            mismatched++;
            $display("FAIL outputs cycle %0d: got %h want %h",
                     n, a, e);
         end
      end
   end

endmodule
